// File: rtl/song_sequencer.sv
// Song playback sequencer: snapshots the packed note/duration/octave buses on start,
// then steps through the slots, holding each for its duration in prescaled beat ticks.
module song_sequencer #(
  parameter int unsigned NOTES    = 56,
  parameter int unsigned TICK_DIV = 12500000,
  parameter int unsigned IDXW     = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 pause,
  input  logic                 loop_en,
  input  logic [NOTES*4-1:0]   song_packed,
  input  logic [NOTES*4-1:0]   time_continue,
  input  logic [NOTES*2-1:0]   octave_packed,
  output logic [3:0]           note_code,
  output logic [1:0]           octave,
  output logic                 sounding,
  output logic [IDXW-1:0]      note_idx,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned SW = NOTES * 4;
  localparam int unsigned OW = NOTES * 2;
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, PLAY, PAUSE, DONE} state_t;

  state_t          state, state_nx;
  logic [SW-1:0]   song_sh, dur_sh, song_snap, dur_snap;
  logic [OW-1:0]   oct_sh, oct_snap;
  logic [PW-1:0]   presc;
  logic [3:0]      cnt;
  logic            tick, clear, load, adv, step, wrap, finish;

  function automatic logic [3:0] nz(input logic [3:0] c);
    return (c == 4'd0) ? 4'd1 : c;
  endfunction

  assign note_code = song_sh[SW-1 -: 4];
  assign octave    = oct_sh[OW-1 -: 2];
  assign sounding  = (state == PLAY);
  assign busy      = (state == PLAY) || (state == PAUSE);
  assign tick      = (presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Timing advances on every PLAY/PAUSE edge with pause low, so the PAUSE->PLAY
  // edge itself counts and only the cycles sampled with pause high are lost.
  always_comb begin
    state_nx = state;
    clear    = 1'b0;
    load     = 1'b0;
    adv      = 1'b0;
    step     = 1'b0;
    wrap     = 1'b0;
    finish   = 1'b0;
    if (stop) begin
      state_nx = IDLE;
      clear    = 1'b1;
    end else if (start) begin
      state_nx = PLAY;
      load     = 1'b1;
    end else begin
      case (state)
        PLAY, PAUSE: begin
          if (pause) begin
            state_nx = PAUSE;
          end else begin
            state_nx = PLAY;
            adv      = 1'b1;
            if (tick && cnt == 4'd1) begin
              if (note_idx != IDXW'(NOTES - 1)) begin
                step = 1'b1;
              end else if (loop_en) begin
                wrap = 1'b1;
              end else begin
                finish   = 1'b1;
                state_nx = DONE;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      song_sh   <= '0;
      dur_sh    <= '0;
      oct_sh    <= '0;
      song_snap <= '0;
      dur_snap  <= '0;
      oct_snap  <= '0;
      presc     <= '0;
      cnt       <= '0;
      note_idx  <= '0;
      done      <= 1'b0;
    end else begin
      done <= finish;
      if (clear) begin
        song_sh  <= '0;
        dur_sh   <= '0;
        oct_sh   <= '0;
        presc    <= '0;
        cnt      <= '0;
        note_idx <= '0;
      end else if (load) begin
        song_sh   <= song_packed;
        dur_sh    <= time_continue;
        oct_sh    <= octave_packed;
        song_snap <= song_packed;
        dur_snap  <= time_continue;
        oct_snap  <= octave_packed;
        presc     <= '0;
        cnt       <= nz(time_continue[SW-1 -: 4]);
        note_idx  <= '0;
      end else if (adv) begin
        presc <= tick ? '0 : presc + PW'(1);
        if (tick) cnt <= cnt - 4'd1;
        if (step) begin
          song_sh  <= {song_sh[SW-5:0], 4'b0};
          dur_sh   <= {dur_sh[SW-5:0], 4'b0};
          oct_sh   <= {oct_sh[OW-3:0], 2'b0};
          cnt      <= nz(dur_sh[SW-5 -: 4]);
          note_idx <= note_idx + IDXW'(1);
        end else if (wrap) begin
          song_sh  <= song_snap;
          dur_sh   <= dur_snap;
          oct_sh   <= oct_snap;
          cnt      <= nz(dur_snap[SW-1 -: 4]);
          note_idx <= '0;
        end else if (finish) begin
          song_sh  <= '0;
          dur_sh   <= '0;
          oct_sh   <= '0;
          presc    <= '0;
          cnt      <= '0;
          note_idx <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Directed self-checking bench for song_sequencer with TICK_DIV=4 (one duration unit = 4 cycles).
module tb_song_sequencer;

  logic         clk = 1'b0;
  logic         rst_n, start, stop, pause, loop_en;
  logic [223:0] song, dur;
  logic [111:0] oct;
  logic [3:0]   note_code;
  logic [1:0]   octave;
  logic         sounding, busy, done;
  logic [5:0]   note_idx;

  int tests = 0;
  int failed = 0;

  song_sequencer #(.NOTES(56), .TICK_DIV(4), .IDXW(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
    .loop_en(loop_en), .song_packed(song), .time_continue(dur),
    .octave_packed(oct), .note_code(note_code), .octave(octave),
    .sounding(sounding), .note_idx(note_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_bus();
    song = '0;
    dur  = '0;
    oct  = '0;
  endtask

  task automatic set_slot(input int i, input logic [3:0] n, input logic [3:0] d, input logic [1:0] o);
    song[223-4*i -: 4] = n;
    dur[223-4*i -: 4]  = d;
    oct[111-2*i -: 2]  = o;
  endtask

  // Returns just after the start edge (E0).
  task automatic do_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic pattern_a();
    clear_bus();
    set_slot(0, 4'd2, 4'd5, 2'd1);
    set_slot(1, 4'd3, 4'd3, 2'd2);
  endtask

  initial begin
    int lowcnt, dcnt, dk;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0;
    clear_bus();
    cyc(2);
    rst_n = 1'b1;
    chk("reset_busy", busy, 0);
    chk("reset_note", note_code, 0);
    chk("reset_done", done, 0);

    // Basic stepping: slot0 lasts 20 cycles, slot1 12 cycles
    pattern_a();
    do_start();
    chk("start_note", note_code, 2);
    chk("start_oct", octave, 1);
    chk("start_idx", note_idx, 0);
    chk("start_sounding", sounding, 1);
    cyc(19);
    chk("slot0_end_note", note_code, 2);
    cyc(1);
    chk("slot1_note", note_code, 3);
    chk("slot1_oct", octave, 2);
    chk("slot1_idx", note_idx, 1);
    cyc(11);
    chk("slot1_end_note", note_code, 3);
    cyc(1);
    chk("slot2_idx", note_idx, 2);
    chk("slot2_note", note_code, 0);

    // Reset mid-play
    do_start();
    cyc(10);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    chk("rst_mid_note", note_code, 0);
    chk("rst_mid_oct", octave, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_sounding", sounding, 0);
    do_start();
    chk("rst_restart_note", note_code, 2);
    cyc(19);
    chk("rst_restart_hold", note_code, 2);
    cyc(1);
    chk("rst_restart_step", note_idx, 1);

    // Pause for 7 sampled edges (E6..E12) inside the 20-cycle slot0
    stop = 1'b1; cyc(1); stop = 1'b0;
    chk("stop_busy", busy, 0);
    do_start();
    lowcnt = 0;
    for (int k = 1; k <= 27; k++) begin
      pause = (k >= 6 && k <= 12);
      cyc(1);
      if (!sounding) lowcnt++;
      if (k == 6) chk("pause_busy", busy, 1);
      if (k == 26) chk("pause_slot0_hold", note_code, 2);
      if (k == 27) chk("pause_slot1", note_idx, 1);
    end
    chk("pause_low_cycles", lowcnt, 7);

    // Snapshot: bus changes after start do not affect playback
    do_start();
    cyc(1);
    song = {56{4'hf}};
    oct  = {56{2'd3}};
    cyc(1);
    chk("snap_note", note_code, 2);
    chk("snap_oct", octave, 1);
    cyc(18);
    chk("snap_slot1", note_code, 3);

    // start+stop together: stop wins
    start = 1'b1; stop = 1'b1;
    cyc(1);
    start = 1'b0; stop = 1'b0;
    chk("startstop_busy", busy, 0);
    chk("startstop_note", note_code, 0);

    // start during PLAY restarts with new bus contents
    pattern_a();
    do_start();
    cyc(5);
    set_slot(0, 4'd9, 4'd2, 2'd3);
    do_start();
    chk("restart_idx", note_idx, 0);
    chk("restart_note", note_code, 9);
    chk("restart_oct", octave, 3);
    cyc(7);
    chk("restart_dur_hold", note_idx, 0);
    cyc(1);
    chk("restart_dur_step", note_idx, 1);

    // All durations zero, no loop: done exactly at E224
    clear_bus();
    for (int i = 0; i < 56; i++) set_slot(i, 4'((i % 15) + 1), 4'd0, 2'd2);
    loop_en = 1'b0;
    do_start();
    dcnt = 0; dk = 0;
    for (int k = 1; k <= 240; k++) begin
      cyc(1);
      if (done) begin dcnt++; dk = k; end
      if (k == 4) chk("zero_dur_step", note_idx, 1);
      if (k == 223) chk("last_slot_note", note_code, 11);
      if (k == 223) chk("last_slot_idx", note_idx, 55);
      if (k == 224) begin
        chk("end_note", note_code, 0);
        chk("end_busy", busy, 0);
      end
    end
    chk("done_cycle", dk, 224);
    chk("done_count", dcnt, 1);
    chk("done_hold_note", note_code, 0);

    // Loop: durations 1, three passes without done
    stop = 1'b1; cyc(1); stop = 1'b0;
    for (int i = 0; i < 56; i++) dur[223-4*i -: 4] = 4'd1;
    loop_en = 1'b1;
    do_start();
    dcnt = 0;
    for (int k = 1; k <= 680; k++) begin
      cyc(1);
      if (done) dcnt++;
      if (k == 223) chk("loop_last_idx", note_idx, 55);
      if (k == 224) begin
        chk("loop_wrap_idx", note_idx, 0);
        chk("loop_wrap_note", note_code, 1);
        chk("loop_wrap_busy", busy, 1);
      end
      if (k == 452) chk("loop_pass3_idx", note_idx, 1);
    end
    chk("loop_no_done", dcnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Playback controller for the song library. On a start command it snapshots the library's packed note, duration and octave buses for the selected song.
- It then steps through the 56 note slots in order, holding each slot for its coded duration in beat ticks.
- It drives the current note code and octave to the downstream tone generator.
- It supports pause/resume, stop, and optional looping, and reports progress and completion to the top-level UI logic.

Parameters:
- NOTES, 56, number of note slots per song.
- TICK_DIV, 12500000, clk cycles per duration tick (tick = 1 unit of duration code).
- IDXW, 6, width of note index (must satisfy 2^IDXW >= NOTES).

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  level-sampled; begin playback from slot 0
- stop  input  1  abort playback, return to idle
- pause  input  1  level; while high in PLAY, freeze
- loop_en  input  1  restart at slot 0 after last slot instead of finishing
- song_packed  input  224  4-bit note codes, slot 0 in [223:220]
- time_continue  input  224  4-bit duration codes, slot 0 in [223:220]
- octave_packed  input  112  2-bit octave codes, slot 0 in [111:110]
- note_code  output  4  current note code
- octave  output  2  current octave code
- sounding  output  1  high while state is PLAY
- note_idx  output  IDXW  current slot index 0..NOTES-1
- busy  output  1  high in PLAY or PAUSE
- done  output  1  one-cycle pulse when the final slot expires with loop_en=0

Behaviour:
- States: IDLE, PLAY, PAUSE, DONE. Reset (rst_n low at a clk edge) applies from any state, including mid-playback:
  - state=IDLE
  - note_code=0, octave=0, note_idx=0
  - sounding=0, busy=0, done=0
  - prescaler=0, duration counter=0, snapshot registers=0
- Command priority per cycle: stop > start > pause.
- IDLE or DONE, start=1:
  - At that edge, capture all three buses into internal shift registers. Later input changes (e.g. song select) do not affect playback until the next start.
  - Set note_idx=0, prescaler=0.
  - Load duration counter with slot-0 duration code; code 0 is treated as 1.
  - Enter PLAY.
  - Slot 0 appears on note_code/octave the following cycle. Latency from start to first output is 1 cycle.
- Outputs note_code/octave are always the top nibble/top 2 bits of the shift registers.
- PLAY:
  - Prescaler counts 0..TICK_DIV-1 and wraps; tick = (prescaler==TICK_DIV-1).
  - On tick, duration counter decrements.
  - On a tick with counter==1, the slot expires. If note_idx<NOTES-1, in the same edge:
    - shift all registers left by one slot (zero-fill),
    - note_idx+1,
    - reload counter from the new slot's duration code (0→1).
  - Slot duration is exactly max(code,1)*TICK_DIV cycles.
- Last-slot expiry (note_idx==NOTES-1):
  - loop_en=1: re-shift from the snapshot copy (a second, unshifted copy is kept), note_idx=0, stay in PLAY, no done pulse.
  - loop_en=0: enter DONE, done=1 for exactly that one cycle, note_code/octave=0.
- PAUSE:
  - PLAY with pause=1 (and no stop/start) → PAUSE at that edge.
  - Prescaler, counter, index and outputs hold; sounding=0, busy=1.
  - pause=0 → PLAY; timing resumes with no lost or extra cycles, apart from the paused cycles themselves.
- start while PLAY/PAUSE: restart from slot 0 with a fresh snapshot (same as IDLE start).
- stop in any state: → IDLE, outputs as reset values (snapshot may keep its content).
- DONE: holds until start (restart) or stop (→IDLE). busy=0, sounding=0.
- The sequencer does not interpret note codes (rests included); the tone generator does.

Test Plan (TICK_DIV=4 in simulation):
- Reset mid-play: play 10 cycles, pulse rst_n low 1 cycle → next cycle all outputs 0, state IDLE; start again plays slot 0 from the beginning.
- Basic step: slot0 note=2/dur=5/oct=1, slot1 note=3/dur=3; start 1 cycle → note_code=2, octave=1 from cycle+1 for 20 cycles, then note_code=3, note_idx=1 for 12 cycles.
- Zero duration and end: all slots dur=0, loop_en=0 → each slot lasts 4 cycles; done pulses once 224 cycles after start; note_code=0, busy=0 afterward.
- Loop: loop_en=1, durations 1 → after slot 55, note_idx returns to 0 with slot-0 note; done never asserts over 3 passes.
- Pause: assert pause 7 cycles in the middle of a 20-cycle slot → slot ends 27 cycles after it began; sounding low exactly 7 cycles.
- Snapshot/priority: change song_packed mid-play → outputs unchanged; start+stop same cycle → IDLE; start during PLAY → note_idx=0 next cycle with the new bus contents.
